apb_master_bridge: RTL and testbench

//  Upstream stage for apb_slave. Converts a simple valid/ready request port into
//  APB3 transfers (SETUP -> ACCESS, with pready wait states). It returns prdata/pslverr
//  on a valid/ready response port. A wait-state watchdog stops a stuck slave from

---
 rtl/apb_master_bridge.sv | 174 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Converts a valid/ready request port into APB3 transfers
//               (SETUP -> ACCESS with pready wait states) and returns
//               read data / error on a valid/ready response port. A wait-state
//               watchdog ends a transfer with an error if the slave never
//               asserts pready. One transfer is outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  // APB3 master port
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int c_wd_width = $clog2(TIMEOUT + 1);
  // Last count value that may still wait; one more stalled cycle trips the watchdog.
  localparam logic [c_wd_width-1:0] c_wd_last = c_wd_width'(TIMEOUT - 1);
  localparam logic [c_wd_width-1:0] c_wd_one  = c_wd_width'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  r_state,     w_state_nxt;
  logic [c_wd_width-1:0]   r_wd,        w_wd_nxt;
  logic                    r_req_ready, w_req_ready;
  logic                    r_psel,      w_psel;
  logic                    r_penable,   w_penable;
  logic                    r_pwrite,    w_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr,     w_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata,    w_pwdata;
  logic                    r_rsp_valid, w_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata;
  logic                    r_rsp_error, w_rsp_error;

  // State and all outputs are registered; async reset aborts any transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= ST_IDLE;
      r_wd        <= '0;
      r_req_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wd        <= w_wd_nxt;
      r_req_ready <= w_req_ready;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_error <= w_rsp_error;
    end
  end

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_req_ready = 1'b0;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_error = r_rsp_error;

    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          // Accept: launch SETUP with the request fields, ready drops next cycle.
          w_state_nxt = ST_SETUP;
          w_psel      = 1'b1;
          w_penable   = 1'b0;
          w_pwrite    = req_write;
          w_paddr     = req_addr;
          w_pwdata    = req_wdata;
          w_wd_nxt    = '0;
        end else begin
          w_req_ready = 1'b1;
        end
      end

      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
        w_penable   = 1'b1;
      end

      ST_ACCESS: begin
        if (pready) begin
          w_state_nxt = ST_RESP;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_pwrite ? '0 : prdata;
          w_rsp_error = pslverr;
        end else if (r_wd == c_wd_last) begin
          // Slave stalled for the full budget: terminate with an error.
          w_state_nxt = ST_RESP;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = '0;
          w_rsp_error = 1'b1;
        end else begin
          w_wd_nxt = r_wd + c_wd_one;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
          w_rsp_valid = 1'b0;
          w_req_ready = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready = r_req_ready;
  assign pselx     = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Self-checking bench for apb_master_bridge with a behavioural
//               APB slave and a reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          pselx, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural slave controls
  int slv_wait_cfg = 0;
  bit slv_hang     = 1'b0;
  int slv_cnt      = 0;
  bit [31:0] slv_mem [256];
  // reference model of what the slave should hold
  bit [31:0] ref_mem [256];

  // per-transfer phase counters from the monitor
  int acc_cnt   = 0;
  int setup_cnt = 0;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Address map of the slave: the top 16 addresses are unmapped.
  function automatic bit is_bad(input logic [7:0] a);
    return a >= 8'hF0;
  endfunction

  // Slave: inserts slv_wait_cfg wait states, errors on unmapped addresses.
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) slv_cnt <= 0;
    else if (pselx && penable && !pready) slv_cnt <= slv_cnt + 1;
    else if (!pselx) slv_cnt <= 0;
  end

  assign pready  = pselx && penable && !slv_hang && (slv_cnt >= slv_wait_cfg);
  assign pslverr = pready && is_bad(paddr);
  assign prdata  = (pselx && !pwrite && !is_bad(paddr)) ? slv_mem[paddr] : '0;

  always @(posedge pclk) begin
    if (pselx && penable && pready && pwrite && !is_bad(paddr))
      slv_mem[paddr] <= pwdata;
  end

  // Protocol monitor: penable implies pselx, APB fields stable while selected.
  logic          prev_sel = 1'b0;
  logic          prev_wr;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wd;
  always @(negedge pclk) begin
    if (penable) begin
      n_checks++;
      if (pselx !== 1'b1) begin
        n_fail++;
        $display("FAIL penable_without_psel: pselx=%b required 1", pselx);
      end
    end
    if (pselx && prev_sel) begin
      n_checks++;
      if (paddr !== prev_addr || pwrite !== prev_wr || pwdata !== prev_wd) begin
        n_fail++;
        $display("FAIL apb_stable: addr=%h wr=%b wd=%h required addr=%h wr=%b wd=%h",
                 paddr, pwrite, pwdata, prev_addr, prev_wr, prev_wd);
      end
    end
    if (pselx && penable)  acc_cnt++;
    if (pselx && !penable) setup_cnt++;
    prev_sel  = pselx;
    prev_wr   = pwrite;
    prev_addr = paddr;
    prev_wd   = pwdata;
  end

  // Issue one request and return the response; lat is the cycle index (the
  // cycle right after the accept edge is 1) in which rsp_valid is first seen.
  task automatic drive_req(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic er);
    int guard;
    lat = -1; rd = '0; er = 1'b0;
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge pclk); #1; guard++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_bound: req_ready=%b after %0d cycles, required 1", req_ready, guard);
      req_valid = 1'b0;
      return;
    end
    acc_cnt = 0; setup_cnt = 0;
    @(posedge pclk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge pclk); #1; lat++;
    end
    if (!rsp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_bound: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
      lat = -1;
      return;
    end
    rd = rsp_rdata; er = rsp_error;
    if (rsp_ready) begin
      @(posedge pclk); #1;
    end
  endtask

  task automatic test_reset();
    logic [77:0] outs;
    presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    outs = {pselx, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_error, req_ready};
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", outs);
    end
    presetn = 1'b1;
    @(posedge pclk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || pselx !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: req_ready=%b pselx=%b required 1/0", req_ready, pselx);
    end
  endtask

  task automatic test_write_basic();
    int lat; logic [31:0] rd; logic er;
    slv_wait_cfg = 0;
    drive_req(1'b1, 8'h12, 32'hDEADBEEF, lat, rd, er);
    ref_mem[8'h12] = 32'hDEADBEEF;
    n_checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL write_basic: lat=%0d err=%b rd=%h required 3/0/0", lat, er, rd);
    end
    n_checks++;
    if (setup_cnt !== 1 || acc_cnt !== 1) begin
      n_fail++; $display("FAIL write_phases: setup=%0d access=%0d required 1/1", setup_cnt, acc_cnt);
    end
  endtask

  task automatic test_read_wait();
    int lat; logic [31:0] rd; logic er;
    slv_wait_cfg = 3;
    drive_req(1'b0, 8'h12, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 6) begin
      n_fail++; $display("FAIL read_wait: rd=%h err=%b lat=%0d required deadbeef/0/6", rd, er, lat);
    end
    n_checks++;
    if (acc_cnt !== 4 || setup_cnt !== 1) begin
      n_fail++; $display("FAIL read_wait_phases: access=%0d setup=%0d required 4/1", acc_cnt, setup_cnt);
    end
  endtask

  task automatic test_slverr();
    int lat; logic [31:0] rd; logic er;
    slv_wait_cfg = 1;
    drive_req(1'b0, 8'hF5, 32'h0, lat, rd, er);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 4) begin
      n_fail++; $display("FAIL slverr: err=%b rd=%h lat=%0d required 1/0/4", er, rd, lat);
    end
    slv_wait_cfg = 0;
    drive_req(1'b0, 8'h12, 32'h0, lat, rd, er);
    n_checks++;
    if (er !== 1'b0 || rd !== ref_mem[8'h12] || lat !== 3) begin
      n_fail++; $display("FAIL after_slverr: err=%b rd=%h lat=%0d required 0/%h/3", er, rd, lat, ref_mem[8'h12]);
    end
  endtask

  task automatic test_timeout();
    int lat; logic [31:0] rd; logic er;
    slv_hang = 1'b1;
    drive_req(1'b0, 8'h12, 32'h0, lat, rd, er);
    n_checks++;
    if (acc_cnt !== TO || lat !== TO + 2) begin
      n_fail++; $display("FAIL timeout_len: access=%0d lat=%0d required %0d/%0d", acc_cnt, lat, TO, TO + 2);
    end
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL timeout_rsp: err=%b rd=%h required 1/0", er, rd);
    end
    n_checks++;
    if (pselx !== 1'b0 || penable !== 1'b0) begin
      n_fail++; $display("FAIL timeout_bus: pselx=%b penable=%b required 0/0", pselx, penable);
    end
    slv_hang = 1'b0;
  endtask

  task automatic test_back_pressure();
    int lat; logic [31:0] rd; logic er;
    logic [7:0]  a2;
    logic [31:0] d2;
    a2 = 8'($urandom_range(0, 15));
    d2 = $urandom;
    slv_wait_cfg = 0;
    rsp_ready = 1'b0;
    drive_req(1'b0, 8'h12, 32'h0, lat, rd, er);
    // keep a second request pending while the response is stalled
    req_write = 1'b1; req_addr = a2; req_wdata = d2; req_valid = 1'b1;
    setup_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[8'h12] || rsp_error !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: req_ready=%b rsp_valid=%b rd=%h err=%b required 0/1/%h/0",
                 i, req_ready, rsp_valid, rsp_rdata, rsp_error, ref_mem[8'h12]);
      end
      @(posedge pclk); #1;
    end
    n_checks++;
    if (setup_cnt !== 0) begin
      n_fail++; $display("FAIL stall_no_setup: setup=%0d required 0", setup_cnt);
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
    end
    @(posedge pclk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (pselx !== 1'b1 || penable !== 1'b0 || paddr !== a2) begin
      n_fail++; $display("FAIL pending_setup: pselx=%b penable=%b addr=%h required 1/0/%h", pselx, penable, paddr, a2);
    end
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge pclk); #1; lat++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL pending_rsp: valid=%b err=%b rd=%h required 1/0/0", rsp_valid, rsp_error, rsp_rdata);
    end
    ref_mem[a2] = d2;
    @(posedge pclk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; int guard; logic [31:0] rd; logic er; logic [31:0] d;
    logic [77:0] outs;
    slv_hang = 1'b1;
    req_write = 1'b1; req_addr = 8'h34; req_wdata = $urandom; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge pclk); #1; guard++;
    end
    @(posedge pclk); #1;
    req_valid = 1'b0;
    @(posedge pclk); #1;
    n_checks++;
    if (pselx !== 1'b1 || penable !== 1'b1) begin
      n_fail++; $display("FAIL mid_access: pselx=%b penable=%b required 1/1", pselx, penable);
    end
    presetn = 1'b0;
    #1;
    outs = {pselx, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_error, req_ready};
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h required 0", outs);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    slv_hang = 1'b0;
    slv_wait_cfg = 1;
    @(posedge pclk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart: req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
    end
    d = $urandom;
    drive_req(1'b1, 8'h34, d, lat, rd, er);
    ref_mem[8'h34] = d;
    n_checks++;
    if (er !== 1'b0 || lat !== 4) begin
      n_fail++; $display("FAIL restart_write: err=%b lat=%0d required 0/4", er, lat);
    end
    drive_req(1'b0, 8'h34, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== d || er !== 1'b0) begin
      n_fail++; $display("FAIL restart_read: rd=%h err=%b required %h/0", rd, er, d);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic er;
    logic wr; logic [7:0] a; logic [31:0] d; int w;
    logic [31:0] exp_rd; logic exp_er;
    for (int i = 0; i < 24; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? 8'(8'hF0 + $urandom_range(0, 15))
                                       : 8'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      w  = $urandom_range(0, 4);
      slv_wait_cfg = w;
      exp_er = is_bad(a);
      exp_rd = (wr || exp_er) ? 32'h0 : ref_mem[a];
      drive_req(wr, a, d, lat, rd, er);
      if (wr && !exp_er) ref_mem[a] = d;
      n_checks++;
      if (rd !== exp_rd || er !== exp_er || lat !== 3 + w || acc_cnt !== w + 1) begin
        n_fail++;
        $display("FAIL random_%0d: wr=%b a=%h rd=%h err=%b lat=%0d acc=%0d required %h/%b/%0d/%0d",
                 i, wr, a, rd, er, lat, acc_cnt, exp_rd, exp_er, 3 + w, w + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_pressure();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
